// File: rtl/iter_multiplier_if.sv
// iter_multiplier_if: operand/product handshake bundle for iter_multiplier.
// master = issuing stage, slave = multiplier.
interface iter_multiplier_if #(
  parameter int XLEN = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              a_signed;
  logic              b_signed;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] out;

  modport master (
    output in_valid, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/iter_multiplier.sv
// iter_multiplier: sign-magnitude iterative multiplier, full 2*XLEN product.
// Define MUL_EARLY_OUT_EN to stop once the remaining multiplier bits are zero.
module iter_multiplier #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  iter_multiplier_if.slave mif
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * XLEN;

  generate
    if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
         BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) ||
        (XLEN % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
      $error("iter_multiplier: illegal BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_nxt;
  logic [PW-1:0]   res;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] mplr;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            a_neg;
  logic            b_neg;
  logic            last;
  logic            valid_q;

  assign a_neg = mif.a_signed & mif.a[XLEN-1];
  assign b_neg = mif.b_signed & mif.b[XLEN-1];
  assign a_mag = a_neg ? -mif.a : mif.a;
  assign b_mag = b_neg ? -mif.b : mif.b;

  // one radix-2^BITS_PER_CYCLE digit as a sum of shifted copies
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplr[i]) pp = pp + (mcand << i);
    end
  end

  assign acc_nxt = acc + pp;
  assign res     = neg ? -acc_nxt : acc_nxt;

`ifdef MUL_EARLY_OUT_EN
  assign last = (cnt == CW'(N - 1)) ||
                ((mplr >> BITS_PER_CYCLE) == '0);
`else
  assign last = (cnt == CW'(N - 1));
`endif

  assign mif.in_ready  = (state == IDLE) && !flush && rst_n;
  assign mif.out_valid = valid_q;
  assign mif.out       = prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      prod    <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mif.in_valid) begin
            mcand <= {{XLEN{1'b0}}, a_mag};
            mplr  <= b_mag;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= '0;
`ifdef MUL_EARLY_OUT_EN
            if (b_mag == '0) begin
              prod    <= '0;
              valid_q <= 1'b1;
              state   <= DONE;
            end else begin
              state   <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          mcand <= mcand << BITS_PER_CYCLE;
          mplr  <= mplr >> BITS_PER_CYCLE;
          cnt   <= cnt + CW'(1);
          if (last) begin
            prod    <= res;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (mif.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_multiplier.sv
// tb_iter_multiplier: directed vectors checked against an arithmetic model.
// in_ready/out_valid/out compared every cycle, plus literal expectations.
module tb_iter_multiplier;
  localparam int XLEN = 64;
  localparam int BPC  = 4;
  localparam int N    = XLEN / BPC;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  iter_multiplier_if #(.XLEN(XLEN)) mif();

  iter_multiplier #(
    .XLEN(XLEN),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .mif(mif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ref_prod(input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b,
                                            input logic as, input logic bs);
    logic [127:0] ea;
    logic [127:0] eb;
    ea = as ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = bs ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic int ref_lat(input logic [XLEN-1:0] b, input logic bs);
    logic [XLEN-1:0] mb;
    int bl;
    int steps;
    mb = (bs && b[XLEN-1]) ? -b : b;
    bl = 0;
    for (int i = 0; i < XLEN; i++) if (mb[i]) bl = i + 1;
    steps = (bl + BPC - 1) / BPC;
    if (steps < 1) steps = 1;
    if (!EO) return N + 1;
    return (bl == 0) ? 1 : 1 + steps;
  endfunction

  // model: 0 idle, 1 busy (counting down to the result), 2 holding result
  int           m_phase = 0;
  int           m_wait  = 0;
  logic         m_valid = 1'b0;
  logic [127:0] m_out   = '0;
  logic [127:0] m_exp   = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_valid = 1'b0;
      m_out   = '0;
    end else if (flush) begin
      m_phase = 0;
      m_valid = 1'b0;
    end else begin
      case (m_phase)
        0: if (mif.in_valid) begin
          m_exp  = ref_prod(mif.a, mif.b, mif.a_signed, mif.b_signed);
          m_wait = ref_lat(mif.b, mif.b_signed) - 1;
          if (m_wait == 0) begin
            m_phase = 2;
            m_valid = 1'b1;
            m_out   = m_exp;
          end else begin
            m_phase = 1;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            m_phase = 2;
            m_valid = 1'b1;
            m_out   = m_exp;
          end
        end
        default: if (mif.out_ready) begin
          m_phase = 0;
          m_valid = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", 128'(mif.in_ready),
          128'((m_phase == 0) && !flush && rst_n));
      chk("cyc_out_valid", 128'(mif.out_valid), 128'(m_valid));
      chk("cyc_out", mif.out, m_out);
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic as, input logic bs);
    bit ok;
    ok = 1'b0;
    mif.a        = a;
    mif.b        = b;
    mif.a_signed = as;
    mif.b_signed = bs;
    mif.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mif.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue: in_ready stayed low, got 0 want 1");
    end
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic [127:0] lit,
                          input int lat_def, input int lat_eo);
    bit seen;
    int k;
    seen = 1'b0;
    k    = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      k = i;
      if (mif.out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: out_valid got 0 want 1 within 200 cycles", nm);
    end else begin
      chk({nm, "_out"}, mif.out, lit);
      chk({nm, "_lat"}, 128'(k), 128'(EO ? lat_eo : lat_def));
    end
  endtask

  task automatic run_op(input string nm, input logic [63:0] a,
                        input logic [63:0] b, input logic as,
                        input logic bs, input logic [127:0] lit,
                        input int lat_def, input int lat_eo);
    issue(a, b, as, bs);
    wait_res(nm, lit, lat_def, lat_eo);
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] BP_LIT = 128'h0000_0000_0000_0001_2345_6789_ABCD_EF00;

  initial begin
    mif.in_valid  = 1'b0;
    mif.a         = '0;
    mif.b         = '0;
    mif.a_signed  = 1'b0;
    mif.b_signed  = 1'b0;
    mif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 128'(mif.out_valid), 128'(0));
    chk("rst_out", mif.out, 128'h0);
    chk("rst_in_ready_low", 128'(mif.in_ready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_high", 128'(mif.in_ready), 128'(1));
    @(posedge clk);
    #1;

    run_op("umax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 17, 17);
    run_op("su", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0,
           128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 17, 17);
    run_op("ss_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 17, 17);
    run_op("ss_m3x7", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, 17, 2);
    run_op("hsu_min", 64'h8000_0000_0000_0000, 64'd2, 1, 0,
           128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 17, 2);
    run_op("max_x_m1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1,
           128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001, 17, 2);
    run_op("b_zero", 64'h1234, 64'h0, 0, 0, 128'h0, 17, 1);
    run_op("nine_x_13", 64'd9, 64'h13, 0, 0, 128'd171, 17, 3);

    // backpressure with a pending request
    mif.out_ready = 1'b0;
    issue(64'h1234_5678_9ABC_DEF0, 64'h10, 0, 0);
    wait_res("bp", BP_LIT, 17, 3);
    mif.a        = 64'd2;
    mif.b        = 64'd3;
    mif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_out", mif.out, BP_LIT);
      chk("bp_hold_valid", 128'(mif.out_valid), 128'(1));
      chk("bp_hold_rdy", 128'(mif.in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    mif.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_rdy", 128'(mif.in_ready), 128'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_after_rdy", 128'(mif.in_ready), 128'(1));
    chk("bp_after_valid", 128'(mif.out_valid), 128'(0));
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
    wait_res("bp_next", 128'd6, 17, 2);
    @(posedge clk);
    #1;

    // flush at CALC step 5 together with a new request
    issue(64'hDEAD, 64'hBEEF_0000_0000_0001, 0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    flush        = 1'b1;
    mif.a        = 64'd3;
    mif.b        = 64'd5;
    mif.in_valid = 1'b1;
    @(negedge clk);
    chk("fl_rdy", 128'(mif.in_ready), 128'(0));
    @(posedge clk);
    #1;
    flush        = 1'b0;
    mif.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_after_rdy", 128'(mif.in_ready), 128'(1));
    chk("fl_after_valid", 128'(mif.out_valid), 128'(0));
    @(posedge clk);
    #1;
    run_op("post_flush", 64'd3, 64'd5, 0, 0, 128'd15, 17, 2);

    // reset in the middle of CALC
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_rdy_low", 128'(mif.in_ready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 128'(mif.out_valid), 128'(0));
    chk("mrst_out", mif.out, 128'h0);
    chk("mrst_rdy", 128'(mif.in_ready), 128'(1));
    @(posedge clk);
    #1;
    run_op("post_rst", 64'd100, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF38, 17, 2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iter_multiplier.md
# iter_multiplier

Parametrised multi-cycle integer multiplier for the NPC execute stage, replacing the single-cycle combinational array where timing closure matters. Accepts two XLEN-bit operands with independent signedness flags over a valid/ready handshake. Produces the full 2·XLEN-bit product after a bounded number of cycles, retiring BITS_PER_CYCLE multiplier bits per cycle. Covers all RV64M multiply flavours (MUL, MULH, MULHSU, MULHU; MULW is handled by operand extension upstream).

## Interface
- `XLEN`, default 64: operand width.
- `BITS_PER_CYCLE`, default 4: multiplier bits consumed per CALC cycle. Legal values are 1, 2, 4 and 8, and XLEN % BITS_PER_CYCLE must be 0. Any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `flush` input 1: kills any in-flight operation (pipeline redirect).
- `in_valid` input 1: operands are valid.
- `in_ready` output 1: the block can accept operands.
- `a` input XLEN: multiplicand.
- `b` input XLEN: multiplier.
- `a_signed` input 1: treat `a` as two's complement.
- `b_signed` input 1: treat `b` as two's complement.
- `out_valid` output 1: the product is available.
- `out_ready` input 1: the consumer takes the product.
- `out` output 2·XLEN: full product, two's complement if either operand is signed.

## Operation
- Let N = XLEN / BITS_PER_CYCLE. The states are IDLE, CALC and DONE.
- `in_ready` = (state == IDLE) && !flush && rst_n.
- **IDLE, on accept (`in_valid && in_ready`):**
  - Latch |a| into a 2·XLEN multiplicand register (zero-extended). Take the magnitude only when `a_signed` is set and a[XLEN-1] is 1.
  - Latch |b| into an XLEN multiplier register, using the same rule with `b_signed`.
  - Store neg = (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]).
  - Clear the accumulator and the step counter, then go to CALC.
- **CALC, each cycle:**
  - Add multiplicand × multiplier[BITS_PER_CYCLE-1:0] to the accumulator. Build this as a sum of BITS_PER_CYCLE shifted multiplicand copies; no `*` operator.
  - Shift the multiplicand left by BITS_PER_CYCLE and the multiplier right by BITS_PER_CYCLE. Increment the counter.
  - After step N, or earlier under MUL_EARLY_OUT_EN, load `out` with the accumulator, two's-complement negated if neg is set, then go to DONE.
- **DONE:** `out_valid` = 1 and `out` is held stable until `out_ready`. On `out_valid && out_ready`, go to IDLE. A new operand is not accepted in the same cycle; `in_ready` rises on the next cycle.
- **Arithmetic:**
  - All accumulation is unsigned in 2·XLEN bits; overflow is impossible because |a|·|b| < 2^(2·XLEN).
  - The most-negative operand magnitude 2^(XLEN-1) is representable in the XLEN-bit register.
- **flush:** in any state, the next state is IDLE and `out_valid` drops next cycle. flush in the same cycle as `in_valid` means no accept. flush wins over `out_ready`.
- **Reset:** state = IDLE, `out_valid` = 0, `out` = 0, accumulator, operand registers and counter = 0. Reset mid-CALC or mid-DONE discards the operation.

## Timing
- Accept on edge T. CALC occupies cycles T+1 … T+N. `out_valid` is asserted from cycle T+N+1. With defaults, N = 16 and the latency is 17 cycles.
- Throughput: one operation per N+2 cycles at most (accept, N CALC cycles, DONE with immediate `out_ready`).
- `out` and `out_valid` are registered. `in_ready` is combinational from state, `flush` and `rst_n` only. There is no combinational path from `in_valid` or `out_ready` to any output.
- `out_ready` low stalls in DONE indefinitely without any change to `out`.

## Configuration
- `MUL_EARLY_OUT_EN` defined:
  - In CALC, if the multiplier register after this cycle's shift is zero, finish immediately: `out` is loaded, DONE follows next cycle, and no remaining steps are performed.
  - If |b| == 0 at accept, go directly from IDLE to DONE with `out` = 0, giving `out_valid` at T+1.
  - Latency becomes 1 + max(1, ceil(bitlen(|b|) / BITS_PER_CYCLE)) cycles for nonzero b.
- `MUL_EARLY_OUT_EN` undefined: CALC always runs exactly N cycles, giving fixed latency N+1.

## Test plan
- Unsigned, a = 0xFFFF_FFFF_FFFF_FFFF, b = 0xFFFF_FFFF_FFFF_FFFF, `out_ready` = 1 → `out` = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Without early-out, `out_valid` is asserted exactly 17 cycles after accept.
- Signed × unsigned, a = -1 (`a_signed`), b = 0xFFFF_FFFF_FFFF_FFFF → `out` = 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001.
- Both signed, a = b = 0x8000_0000_0000_0000 → `out` = 0x4000_0000_0000_0000_0000_0000_0000_0000. Also a = -3, b = 7 → `out` = -21 sign-extended to 128 bits.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE → `out` stable, `in_ready` = 0, and a pending `in_valid` is not accepted until the cycle after the `out_ready` handshake.
- flush asserted at CALC step 5 together with `in_valid` → no accept. `in_ready` = 1 the cycle after. A fresh 3 × 5 then yields 15 with no residue from the killed operation.
- With MUL_EARLY_OUT_EN: b = 0 → `out_valid` at T+1 with `out` = 0; a = 9, b = 0x13 → `out_valid` at T+3 with `out` = 171. Toggle `rst_n` low mid-CALC → `out_valid` = 0, `out` = 0, and `in_ready` = 1 after release.
